instr_mem_writer: RTL
=====================

# instr_mem_writer

Sequential RISC-V RV32I instruction encoder and program loader. It is the producer-side counterpart of the opcode decoder in the control unit. It takes instruction fields over a valid/ready handshake and packs them into 32-bit words with the opcodes 0110011, 0010011, 0000011, 0100011, 1100011 and 1101111. It writes each word sequentially into instruction memory through an address counter with memory back-pressure. It sits between the testbench/boot source and the instruction memory of the single-cycle core.

## Interface
- ADDR_W, 8: word-address width; memory depth 2^ADDR_W
- BASE_ADDR, 0: first word address after reset/clear
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear: address←BASE_ADDR, count←0, leave FULL, abort pending write
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept; combinational: (state==IDLE) && !clr
- in_class  in  3  0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 jal, 6–7 illegal
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  signed byte-offset/immediate
- mem_we  out  1  write request, registered
- mem_addr  out  ADDR_W  word address, registered
- mem_wdata  out  32  encoded word, registered
- mem_ready  in  1  memory accepts write this cycle when mem_we && mem_ready
- count  out  ADDR_W+1  words written since reset/clr
- full  out  1  last address written
- err  out  1  one-cycle illegal-input pulse (0 unless INSTR_CHECK_EN)

## Operation
- States: IDLE, WRITE, FULL.
- IDLE: accept on in_valid && in_ready → encode and register mem_wdata, mem_we←1, go to WRITE.
- WRITE: hold mem_we, mem_addr and mem_wdata stable until mem_ready. On completion:
  - count+1, mem_we←0.
  - If mem_addr == 2^ADDR_W−1 → FULL, address held.
  - Else address+1 → IDLE.
- FULL: in_ready=0, full=1; inputs ignored; only clr or rst exit, both to IDLE.
- Encodings (imm bits taken from in_imm):
  - R: f7|rs2|rs1|f3|rd|0110011
  - I / load: imm[11:0]|rs1|f3|rd|opcode
  - store: imm[11:5]|rs2|rs1|f3|imm[4:0]|0100011
  - branch: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|1100011
  - jal: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|1101111
- Unused fields are ignored. Out-of-range immediates are truncated. imm[0] is dropped for branch/jal.

## Timing
- Reset values: state IDLE, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, count 0, full 0, err 0.
- Accept in cycle N → mem_we=1 with valid addr/data in cycle N+1.
- Peak throughput: one word per 2 cycles with mem_ready tied high.
- clr has priority in every state. mem_we=0 in the cycle after clr; an aborted write does not increment count.
- rst mid-WRITE clears mem_we immediately (asynchronous).
- No input buffering: fields are sampled only at the accept edge.

## Configuration
- INSTR_CHECK_EN defined:
  - These inputs are rejected at accept:
    - in_class 6/7
    - I/load/store imm outside [−2048, 2047]
    - branch imm outside [−4096, 4094] or odd
    - jal imm outside [−2^20, 2^20−2] or odd
  - Rejection: handshake completes, no write, count unchanged, err=1 in cycle N+1, stays IDLE.
- Not defined:
  - err tied 0.
  - Classes 6/7 are written as NOP 0x00000013.
  - Immediates are truncated silently.

## Test plan
- R add: class0 rd3 rs1 1 rs2 2 f3 0 f7 0 → mem_wdata 0x002081B3 at addr 0, count 1.
- Branch beq: class4 rs1 1 rs2 2 imm −8 → 0xFE208CE3; jal class5 rd1 imm 16 → 0x010000EF at next address.
- Back-pressure: mem_ready low 3 cycles after accept → mem_we, addr and data stable and in_ready 0 throughout; address increments only after mem_ready high.
- Full: ADDR_W=2, four writes → full=1, in_ready=0, fifth in_valid ignored; clr → mem_addr 0, count 0, full 0.
- Reset/clear mid-write: rst during WRITE → mem_we 0 immediately, count 0. clr during WRITE → no increment.
- Immediate 2048 on I-type:
  - With INSTR_CHECK_EN: err pulse, no mem_we.
  - Without: word 0x80000013 written with rd0 rs1 0 f3 0.

Source files
------------

// File: rtl/instr_mem_writer.sv
// RV32I instruction encoder/loader: packs instruction fields into words and writes them sequentially to instruction memory.
// Optional INSTR_CHECK_EN rejects illegal classes and out-of-range immediates with a one-cycle err pulse.
`timescale 1ns/1ps
module instr_mem_writer #(
  parameter int unsigned           ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_err;

  logic [31:0]       w_word;
  logic              w_illegal;

  always_comb begin
    w_word = 32'h0000_0013;
    case (in_class)
      3'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
      3'd1: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
      3'd2: w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
      3'd3: w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
      3'd4: w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], 7'b1100011};
      3'd5: w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
      default: w_word = 32'h0000_0013;
    endcase
  end

`ifdef INSTR_CHECK_EN
  logic signed [31:0] w_imm_s;
  assign w_imm_s = $signed(in_imm);

  always_comb begin
    w_illegal = 1'b0;
    case (in_class)
      3'd1, 3'd2, 3'd3:
        w_illegal = (w_imm_s < -32'sd2048) || (w_imm_s > 32'sd2047);
      3'd4:
        w_illegal = (w_imm_s < -32'sd4096) || (w_imm_s > 32'sd4094) || in_imm[0];
      3'd5:
        w_illegal = (w_imm_s < -32'sd1048576) || (w_imm_s > 32'sd1048574) || in_imm[0];
      3'd6, 3'd7:
        w_illegal = 1'b1;
      default:
        w_illegal = 1'b0;
    endcase
  end
`else
  logic w_unused_imm;
  assign w_unused_imm = ^in_imm[31:21];
  assign w_illegal    = 1'b0;
`endif

  assign in_ready  = (r_state == ST_IDLE) && !clr;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign full      = (r_state == ST_FULL);
  assign err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDR;
      r_wdata <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (clr) begin
        // clr wins over a completing write, so an aborted word is never counted
        r_state <= ST_IDLE;
        r_we    <= 1'b0;
        r_addr  <= BASE_ADDR;
        r_count <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (in_valid) begin
              if (w_illegal) begin
                r_err <= 1'b1;
              end else begin
                r_wdata <= w_word;
                r_we    <= 1'b1;
                r_state <= ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            if (mem_ready) begin
              r_we    <= 1'b0;
              r_count <= r_count + CNT_ONE;
              if (r_addr == {ADDR_W{1'b1}}) begin
                r_state <= ST_FULL;
              end else begin
                r_addr  <= r_addr + ADDR_ONE;
                r_state <= ST_IDLE;
              end
            end
          end
          ST_FULL: r_state <= ST_FULL;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
